// File: rtl/core_debug_ctrl.sv
// core_debug_ctrl
//   Run-control unit for the rv32i core. It decodes keyed logic-analyser
//   commands into the following actions:
//     - run / halt
//     - N-instruction single-step
//     - timed soft reset
//     - NUM_BP PC breakpoints
//   It drives the core's combined stall and soft reset.
//
// Ports
//   clk          core clock (after the clock-select mux)
//   reset        asynchronous active-high reset
//   la_data_in   LA command word: [31] go, [30:28] opcode, [27:0] argument
//   la_oenb      LA output-enable bar; a command is qualified only when it equals OENB_KEY
//   ext_stall_i  external io stall
//   mem_stall_i  memory controller stall
//   pc_i         current fetch PC from the core
//   stall_o      stall to the core
//   soft_reset_o soft reset to the core and the memory controller
//   halted_o     high while halted
//   status_o     {step_cnt, hit_idx, skip, bp_hit, state}, zero-padded to 32 bits
module core_debug_ctrl #(
    parameter int          XLEN       = 32,
    parameter int          NUM_BP     = 2,
    parameter int          STEP_W     = 8,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] OENB_KEY   = 32'hFFFFFFF0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     la_data_in,
    input  logic [31:0]     la_oenb,
    input  logic            ext_stall_i,
    input  logic            mem_stall_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_o,
    output logic            soft_reset_o,
    output logic            halted_o,
    output logic [31:0]     status_o
);

    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    localparam logic [2:0] OP_RUN   = 3'd0;
    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_STEP  = 3'd2;
    localparam logic [2:0] OP_SETBP = 3'd4;
    localparam logic [2:0] OP_CLRBP = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_STEP  = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    state_t              state;
    logic                go_q;
    logic [NUM_BP-1:0]   bp_en;
    logic [XLEN-1:0]     bp_addr [NUM_BP];
    logic [STEP_W-1:0]   step_cnt;
    logic [RC_W-1:0]     rst_cnt;
    logic                post_halt;
    logic                bp_hit;
    logic                skip;
    logic [3:0]          hit_idx;

    logic [2:0]          op;
    logic [27:0]         arg;
    logic [3:0]          bp_idx;
    logic                cmd_v;
    logic [NUM_BP-1:0]   bp_vec;
    logic                bp_match;
    logic [3:0]          hit_idx_c;
    logic                running;
    logic                hit;
    logic                adv;
    logic                unused_bits;

    assign op     = la_data_in[30:28];
    assign arg    = la_data_in[27:0];
    assign bp_idx = arg[27:24];

    // Only the rising edge of the go bit counts, so a held go bit runs once.
    assign cmd_v = la_data_in[31] & ~go_q & (la_oenb == OENB_KEY);

    // Bits 23:22 of the argument carry nothing for any opcode.
    assign unused_bits = ^la_data_in[23:22];

    always_comb begin
        hit_idx_c = 4'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_vec[i] = bp_en[i] & (bp_addr[i] == pc_i);
        end
        // Walk downwards so the lowest matching comparator wins.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_vec[i]) begin
                hit_idx_c = 4'(i);
            end
        end
    end

    // skip masks the comparators for the first retire after a resume,
    // letting the core step off the breakpointed PC.
    assign bp_match = (|bp_vec) & ~skip;
    assign running  = (state == ST_RUN) | (state == ST_STEP);
    assign hit      = running & bp_match;
    assign adv      = running & ~ext_stall_i & ~mem_stall_i & ~bp_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            go_q      <= 1'b0;
            bp_en     <= '0;
            step_cnt  <= '0;
            rst_cnt   <= '0;
            post_halt <= 1'b0;
            bp_hit    <= 1'b0;
            skip      <= 1'b0;
            hit_idx   <= 4'd0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else begin
            go_q <= la_data_in[31];
            if (state == ST_RESET) begin
                // Only a fresh SRST is heard while the soft reset is running.
                if (cmd_v && (op == 3'd3)) begin
                    rst_cnt   <= RC_W'(RST_CYCLES);
                    post_halt <= arg[0];
                    bp_hit    <= 1'b0;
                end else begin
                    rst_cnt <= rst_cnt - RC_W'(1);
                    if (rst_cnt == RC_W'(1)) begin
                        state <= post_halt ? ST_HALT : ST_RUN;
                    end
                end
            end else if (cmd_v && !op[2]) begin
                // State-changing commands take precedence over a breakpoint
                // halt or step expiry on the same edge. Resuming on the hit
                // cycle counts as resuming from HALT.
                bp_hit <= 1'b0;
                if (((op == OP_RUN) || (op == OP_STEP)) && ((state == ST_HALT) || hit)) begin
                    skip <= 1'b1;
                end else if (adv) begin
                    skip <= 1'b0;
                end
                case (op)
                    OP_RUN:  state <= ST_RUN;
                    OP_HALT: state <= ST_HALT;
                    OP_STEP: begin
                        step_cnt <= arg[STEP_W-1:0];
                        state    <= (arg[STEP_W-1:0] == '0) ? ST_HALT : ST_STEP;
                    end
                    default: begin
                        rst_cnt   <= RC_W'(RST_CYCLES);
                        post_halt <= arg[0];
                        state     <= ST_RESET;
                    end
                endcase
            end else begin
                // Breakpoint table commands and no-ops leave the state alone;
                // an accepted command still suppresses a same-edge breakpoint
                // halt (the core stays stalled on that PC, so it re-hits).
                if (cmd_v) begin
                    bp_hit <= 1'b0;
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (bp_idx == 4'(i)) begin
                            if (op == OP_SETBP) begin
                                bp_en[i]   <= 1'b1;
                                bp_addr[i] <= XLEN'({arg[21:0], 2'b00});
                            end else if (op == OP_CLRBP) begin
                                bp_en[i] <= 1'b0;
                            end
                        end
                    end
                end else if (hit) begin
                    state   <= ST_HALT;
                    bp_hit  <= 1'b1;
                    hit_idx <= hit_idx_c;
                end
                if (adv) begin
                    skip <= 1'b0;
                    if (state == ST_STEP) begin
                        step_cnt <= step_cnt - STEP_W'(1);
                        if (step_cnt == STEP_W'(1)) begin
                            state <= ST_HALT;
                        end
                    end
                end
            end
        end
    end

    assign stall_o      = ext_stall_i | mem_stall_i | (state == ST_HALT) |
                          (state == ST_RESET) | bp_match;
    assign soft_reset_o = (state == ST_RESET);
    assign halted_o     = (state == ST_HALT);

    always_comb begin
        status_o              = '0;
        status_o[1:0]         = state;
        status_o[2]           = bp_hit;
        status_o[3]           = skip;
        status_o[7:4]         = hit_idx;
        status_o[8 +: STEP_W] = step_cnt;
    end

endmodule

// File: doc/core_debug_ctrl.md
Name: core_debug_ctrl

Overview:
- Parametrised run-control unit for the rv32i core; successor to the fixed two-bit logic-analyser stall/reset latch in the top wrapper.
- Decodes keyed logic-analyser commands into run/halt, N-instruction single-step, timed soft reset and NUM_BP PC breakpoints.
- Drives the core's combined stall and soft reset.
- Sits between the LA pins, the memory controller stall and the processor.

Parameters:
- XLEN, 32, PC / breakpoint address width.
- NUM_BP, 2, number of PC breakpoint comparators (1..16).
- STEP_W, 8, width of the step counter (1..16).
- RST_CYCLES, 4, soft reset pulse length in cycles (>=1).
- OENB_KEY, 32'hFFFFFFF0, la_oenb value that qualifies a command.

Ports:
- clk  in  1  core clock (post clock-select mux).
- reset  in  1  asynchronous active-high reset.
- la_data_in  in  32  LA command word.
- la_oenb  in  32  LA output-enable bar; commands are accepted only when equal to OENB_KEY.
- ext_stall_i  in  1  external io stall.
- mem_stall_i  in  1  memory controller stall.
- pc_i  in  XLEN  current fetch PC from the core.
- stall_o  out  1  stall to the core.
- soft_reset_o  out  1  soft reset to the core and memory controller.
- halted_o  out  1  high while in HALT.
- status_o  out  32  status word, readable through the LA.

Behaviour:
- Async reset: state=RUN, all bp_en=0, bp_addr=0, step_cnt=0, rst_cnt=0, bp_hit=0, skip=0, go_q=0.
- Async reset output values: stall_o=ext_stall_i|mem_stall_i, soft_reset_o=0, halted_o=0.
- Command strobe, registered on posedge clk:
  - go_q <= la_data_in[31].
  - cmd_v = la_data_in[31] & ~go_q & (la_oenb==OENB_KEY).
  - A held go bit executes only once; a key mismatch on the rising edge drops the command.
- Command fields: op=la_data_in[30:28], arg=la_data_in[27:0].
- Opcodes:
  - 0 RUN: go to RUN.
  - 1 HALT: go to HALT.
  - 2 STEP: step_cnt<=arg[STEP_W-1:0]; go to STEP, or straight to HALT if the count is 0.
  - 3 SRST: rst_cnt<=RST_CYCLES; go to RESET; arg[0] selects the post-reset state (1=HALT, 0=RUN).
  - 4 SETBP: idx=arg[27:24]; bp_addr[idx]<={zero-extended arg[21:0],2'b00}; bp_en[idx]<=1. Ignored if idx>=NUM_BP.
  - 5 CLRBP: bp_en[idx]<=0.
  - 6, 7: no operation.
- Every accepted command clears bp_hit.
- SETBP and CLRBP do not change state.
- RUN and STEP issued from HALT set skip=1.
- States: RUN=0, HALT=1, STEP=2, RESET=3.
- Retire condition: adv = (state is RUN or STEP) & ~ext_stall_i & ~mem_stall_i & ~bp_match_q.
- bp_match (combinational): any enabled bp_addr[i]==pc_i, with skip==0.
  - bp_match_q is that same combinational term, used in the same cycle.
  - On a match, stall_o asserts in the same cycle.
  - Next edge: state->HALT, bp_hit<=1, hit_idx<=lowest matching index.
- skip clears on the first adv cycle. This lets the core leave the breakpointed PC on resume.
- STEP: each adv cycle decrements step_cnt; on the cycle it goes 1->0, state->HALT at the same edge.
  - Stalls freeze step_cnt.
  - A breakpoint hit during STEP halts and leaves the remaining count in step_cnt.
- RESET: soft_reset_o=1 and stall_o=1; rst_cnt decrements every cycle.
  - When rst_cnt reaches 1, the next state is the state selected by arg[0].
  - Commands other than a new SRST are ignored in RESET. A new SRST reloads rst_cnt.
- Outputs:
  - stall_o = ext_stall_i | mem_stall_i | (state==HALT) | (state==RESET) | bp_match.
  - halted_o = (state==HALT).
- Simultaneous events: on the same edge, a command overrides a breakpoint halt or a step-count expiry. For example, a RUN command on the hit cycle leaves the unit in RUN with skip=1.
- status_o layout:
  - [1:0] state
  - [2] bp_hit
  - [3] skip
  - [7:4] hit_idx
  - [8+STEP_W-1:8] step_cnt
  - remaining bits 0.

Test Plan:
- Reset behaviour: assert reset mid-STEP with step_cnt=5 -> state=RUN, status_o=0, stall_o follows the stall inputs, soft_reset_o=0 immediately (asynchronous).
- Step with memory stalls: HALT, then STEP 3 while mem_stall_i is high for 2 cycles inside the window -> exactly 3 unstalled cycles pass, then halted_o=1 and status step field=0.
- Breakpoint hit and resume: SETBP idx1 addr 0x40 in RUN, pc_i reaches 0x40 -> stall_o high that cycle, next cycle halted_o=1, status bits [2]=1 and [7:4]=1. Then RUN -> one adv cycle at 0x40 without re-halt, skip clears.
- Soft reset: SRST arg0=1 with RST_CYCLES=4 -> soft_reset_o high for exactly 4 cycles, then HALT. SRST arg0=0 -> RUN afterwards.
- Command qualification: go bit held high for 10 cycles -> one execution only. Go rising while la_oenb=0xFFFFFFFF -> ignored. SETBP idx=NUM_BP -> no change.
- Command overrides breakpoint: HALT command on the same edge as a breakpoint match -> HALT with bp_hit=0. RUN command on the hit edge -> RUN with skip=1.
